regfile_scoreboard: RTL and testbench



---
 rtl/regfile_scoreboard.sv | 123 ++++++++++++
 tb/tb_regfile_scoreboard.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: architectural register file with write-first bypass
// and a per-register pending-write scoreboard.
//
// Decode counts each issued writer against its destination. Writeback or a
// squash releases one count per event. Decode sees a busy flag for each read
// port and a stall when a destination counter is full. Register 0 reads as
// zero, ignores writes and is never tracked.
module regfile_scoreboard #(
   parameter int NREG   = 32,
   parameter int XLEN   = 32,
   parameter int PEND_W = 2
) (
   input  logic                     clk,
   input  logic                     reset_n,
   // writeback port
   input  logic                     RegWriteW,
   input  logic [$clog2(NREG)-1:0]  WriteRegW,
   input  logic [XLEN-1:0]          ResultW,
   // decode read ports
   input  logic [$clog2(NREG)-1:0]  A1D,
   input  logic [$clog2(NREG)-1:0]  A2D,
   output logic [XLEN-1:0]          RD1D,
   output logic [XLEN-1:0]          RD2D,
   // scoreboard
   input  logic                     IssueD,
   input  logic [$clog2(NREG)-1:0]  DestD,
   input  logic                     KillE,
   input  logic [$clog2(NREG)-1:0]  KillDestE,
   output logic                     Busy1D,
   output logic                     Busy2D,
   output logic                     StallIssueD,
   output logic                     PendErr
);

   localparam int AW = $clog2(NREG);
   // The counter arithmetic carries two extra bits. One bit gives headroom
   // for +1. The MSB is the sign bit and flags underflow.
   localparam int CW = PEND_W + 2;
   localparam logic [PEND_W-1:0] PEND_MAX = '1;

   logic [XLEN-1:0]   regs      [NREG];
   logic [PEND_W-1:0] pend      [NREG];
   logic [PEND_W-1:0] pend_next [NREG];
   logic [1:0]        dec_cnt   [NREG];
   logic [CW-1:0]     pend_sum  [NREG];
   logic              underflow;
   logic              inc_ok;
   logic [CW-1:0]     left1;
   logic [CW-1:0]     left2;

   // The stall looks only at the registered count. A release in the same
   // cycle does not lift it.
   assign StallIssueD = IssueD && (DestD != '0) && (pend[DestD] == PEND_MAX);
   assign inc_ok      = IssueD && !StallIssueD;

   // Per-register next count: issue adds one; writeback and kill each
   // subtract one. A negative result clamps to zero and raises underflow.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path leaves a latch.
      underflow = 1'b0;
      for (int r = 0; r < NREG; r++) begin
         dec_cnt[r]   = '0;
         pend_sum[r]  = '0;
         pend_next[r] = '0;
         if (r != 0) begin
            dec_cnt[r]  = 2'(RegWriteW && (WriteRegW == AW'(r)))
                        + 2'(KillE && (KillDestE == AW'(r)));
            pend_sum[r] = {2'b00, pend[r]}
                        + CW'(inc_ok && (DestD == AW'(r)))
                        - CW'(dec_cnt[r]);
            if (pend_sum[r][CW-1]) begin
               underflow = 1'b1;
            end else begin
               pend_next[r] = pend_sum[r][PEND_W-1:0];
            end
         end
      end
   end

   // Busy means writes are still outstanding after this cycle's releases.
   // A writer completing now is covered by the bypass.
   assign left1  = {2'b00, pend[A1D]} - CW'(dec_cnt[A1D]);
   assign left2  = {2'b00, pend[A2D]} - CW'(dec_cnt[A2D]);
   assign Busy1D = (A1D != '0) && !left1[CW-1] && (left1 != '0);
   assign Busy2D = (A2D != '0) && !left2[CW-1] && (left2 != '0);

   // Read ports are write-first: a same-cycle writeback to the address wins.
   always_comb begin
      RD1D = '0;
      RD2D = '0;
      if (A1D != '0) begin
         RD1D = (RegWriteW && (WriteRegW == A1D)) ? ResultW : regs[A1D];
      end
      if (A2D != '0) begin
         RD2D = (RegWriteW && (WriteRegW == A2D)) ? ResultW : regs[A2D];
      end
   end

   // State update: register writes, counters and the sticky error flag.
   // NOTE: every register clears on reset, so this array is built from flops
   // and not from a RAM macro.
   always_ff @(posedge clk) begin
      // NOTE: use non-blocking assignments so every flop samples pre-edge values.
      if (!reset_n) begin
         for (int r = 0; r < NREG; r++) begin
            regs[r] <= '0;
            pend[r] <= '0;
         end
         PendErr <= 1'b0;
      end else begin
         if (RegWriteW && (WriteRegW != '0)) begin
            regs[WriteRegW] <= ResultW;
         end
         for (int r = 0; r < NREG; r++) begin
            pend[r] <= pend_next[r];
         end
         if (underflow) begin
            PendErr <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Testbench for regfile_scoreboard.
// Directed steps follow the register file and scoreboard rules, then
// randomized traffic runs. Every output is compared each cycle against a
// behavioural model that holds register values and pending counts as ints.
module tb_regfile_scoreboard;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        RegWriteW;
   logic [4:0]  WriteRegW;
   logic [31:0] ResultW;
   logic [4:0]  A1D, A2D;
   logic [31:0] RD1D, RD2D;
   logic        IssueD;
   logic [4:0]  DestD;
   logic        KillE;
   logic [4:0]  KillDestE;
   logic        Busy1D, Busy2D, StallIssueD, PendErr;

   regfile_scoreboard #(.NREG(32), .XLEN(32), .PEND_W(2)) dut (
      .clk(clk), .reset_n(reset_n),
      .RegWriteW(RegWriteW), .WriteRegW(WriteRegW), .ResultW(ResultW),
      .A1D(A1D), .A2D(A2D), .RD1D(RD1D), .RD2D(RD2D),
      .IssueD(IssueD), .DestD(DestD), .KillE(KillE), .KillDestE(KillDestE),
      .Busy1D(Busy1D), .Busy2D(Busy2D), .StallIssueD(StallIssueD),
      .PendErr(PendErr)
   );

   always #5 clk = ~clk;

   // reference model state
   logic [31:0] m_regs [32];
   int          m_pend [32];
   bit          m_err;

   int n_cmp = 0;
   int n_err = 0;
   int cyc_n = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s cyc=%0d: observed %h expected %h", tag, cyc_n, obs, exp);
      end
   endtask

   function automatic int mdec(input int r);
      return int'(RegWriteW && int'(WriteRegW) == r) + int'(KillE && int'(KillDestE) == r);
   endfunction

   function automatic logic mstall();
      return IssueD && DestD != 0 && m_pend[DestD] == 3;
   endfunction

   function automatic logic [31:0] mread(input logic [4:0] a);
      if (a == 0) return 32'h0;
      if (RegWriteW && WriteRegW == a) return ResultW;
      return m_regs[a];
   endfunction

   // Compare every output against the model. Outputs are skipped during reset cycles.
   task automatic check_model();
      if (reset_n) begin
         check("rd1",   RD1D, mread(A1D));
         check("rd2",   RD2D, mread(A2D));
         check("busy1", 32'(Busy1D), 32'(A1D != 0 && (m_pend[A1D] - mdec(int'(A1D))) > 0));
         check("busy2", 32'(Busy2D), 32'(A2D != 0 && (m_pend[A2D] - mdec(int'(A2D))) > 0));
         check("stall", 32'(StallIssueD), 32'(mstall()));
         check("perr",  32'(PendErr), 32'(m_err));
      end
   endtask

   task automatic drive(input logic rst, input logic we, input logic [4:0] wreg,
                        input logic [31:0] wdata, input logic [4:0] a1, input logic [4:0] a2,
                        input logic iss, input logic [4:0] dest,
                        input logic kill, input logic [4:0] kdest);
      reset_n = rst; RegWriteW = we; WriteRegW = wreg; ResultW = wdata;
      A1D = a1; A2D = a2; IssueD = iss; DestD = dest; KillE = kill; KillDestE = kdest;
      #1;
      check_model();
   endtask

   // Advance one edge and apply the same edge to the model.
   task automatic tick();
      bit st;
      @(posedge clk);
      if (!reset_n) begin
         for (int r = 0; r < 32; r++) begin
            m_regs[r] = 32'h0;
            m_pend[r] = 0;
         end
         m_err = 1'b0;
      end else begin
         st = mstall();
         if (RegWriteW && WriteRegW != 0) m_regs[WriteRegW] = ResultW;
         for (int r = 1; r < 32; r++) begin
            int p;
            p = m_pend[r] + int'(IssueD && int'(DestD) == r && !st) - mdec(r);
            if (p < 0) begin
               p = 0;
               m_err = 1'b1;
            end
            m_pend[r] = p;
         end
      end
      cyc_n++;
      @(negedge clk);
   endtask

   task automatic idle(input logic [4:0] a1);
      drive(1, 0, 0, 0, a1, 0, 0, 0, 0, 0);
   endtask

   initial begin
      for (int r = 0; r < 32; r++) begin
         m_regs[r] = 32'h0;
         m_pend[r] = 0;
      end
      m_err = 1'b0;
      @(negedge clk);

      // reset while a write to r5 is presented
      drive(0, 1, 5, 32'h5555_5555, 5, 0, 0, 0, 0, 0); tick();
      drive(0, 1, 5, 32'h5555_5555, 5, 0, 0, 0, 0, 0); tick();
      drive(1, 0, 0, 0, 5, 0, 1, 5, 0, 0);
      check("rst_rd1", RD1D, 32'h0);
      check("rst_perr", 32'(PendErr), 32'h0);
      tick();
      drive(1, 1, 5, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0); tick();
      idle(5);
      check("r5_read", RD1D, 32'hDEAD_BEEF);
      tick();

      // bypass, and r0 stays zero
      drive(1, 0, 0, 0, 0, 0, 1, 7, 0, 0); tick();
      drive(1, 1, 7, 32'h1234, 0, 7, 0, 0, 0, 0);
      check("bypass_rd2", RD2D, 32'h1234);
      tick();
      drive(1, 1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0);
      check("r0_rd1", RD1D, 32'h0);
      tick();

      // issue then writeback of r3
      drive(1, 0, 0, 0, 3, 0, 1, 3, 0, 0); tick();
      idle(3);
      check("busy_r3", 32'(Busy1D), 32'h1);
      tick();
      drive(1, 1, 3, 32'hA5A5_0003, 3, 0, 0, 0, 0, 0);
      check("wb_busy_r3", 32'(Busy1D), 32'h0);
      check("wb_rd1_r3", RD1D, 32'hA5A5_0003);
      tick();
      idle(3);
      check("clear_r3", 32'(Busy1D), 32'h0);
      tick();

      // saturation on r9
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 0, 0, 9, 0, 1, 9, 0, 0);
         check("sat_nostall", 32'(StallIssueD), 32'h0);
         tick();
      end
      drive(1, 0, 0, 0, 9, 0, 1, 9, 0, 0);
      check("sat_stall", 32'(StallIssueD), 32'h1);
      tick();
      drive(1, 0, 0, 0, 9, 0, 1, 9, 1, 9);
      check("sat_kill_stall", 32'(StallIssueD), 32'h1);
      tick();
      drive(1, 0, 0, 0, 9, 0, 1, 9, 0, 0);
      check("sat_release", 32'(StallIssueD), 32'h0);
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 0, 0, 9, 0, 0, 0, 1, 9); tick();
      end
      idle(9);
      check("r9_drained", 32'(Busy1D), 32'h0);
      tick();

      // writeback + kill + issue on r4 in one cycle, starting from pend=2
      drive(1, 0, 0, 0, 0, 0, 1, 4, 0, 0); tick();
      drive(1, 0, 0, 0, 0, 0, 1, 4, 0, 0); tick();
      drive(1, 1, 4, 32'h0000_4444, 4, 0, 1, 4, 1, 4);
      check("simul_busy", 32'(Busy1D), 32'h0);
      tick();
      idle(4);
      check("simul_left1", 32'(Busy1D), 32'h1);
      tick();
      drive(1, 1, 4, 32'h0000_4445, 0, 0, 0, 0, 0, 0); tick();

      // underflow is sticky until reset
      drive(1, 1, 6, 32'h6666, 0, 0, 0, 0, 0, 0);
      check("uf_before", 32'(PendErr), 32'h0);
      tick();
      idle(0);
      check("uf_set", 32'(PendErr), 32'h1);
      tick();
      idle(0);
      check("uf_sticky", 32'(PendErr), 32'h1);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
      idle(6);
      check("uf_cleared", 32'(PendErr), 32'h0);
      check("uf_rst_rd", RD1D, 32'h0);
      tick();

      // randomized traffic on a small register window to force collisions
      for (int i = 0; i < 800; i++) begin
         logic [4:0] wr, a1, a2, ds, kd;
         wr = 5'($urandom_range(0, 7));
         a1 = 5'($urandom_range(0, 7));
         a2 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
         ds = 5'($urandom_range(0, 7));
         kd = 5'($urandom_range(0, 7));
         drive(($urandom_range(0, 99) != 0),
               ($urandom_range(0, 2) == 0), wr, $urandom,
               a1, a2,
               ($urandom_range(0, 1) == 0), ds,
               ($urandom_range(0, 5) == 0), kd);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
